// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache; read hits answer combinationally.
// Misses and stores hold the datapath via stall until the backing memory handshake completes.
module data_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_re,
   input  logic                    cpu_we,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_be,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_ready,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
);
   localparam int IB = $clog2(SETS);
   localparam int TB = ADDR_WIDTH - IB - 2;
   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_t;
   state_t state_q, state_d;

   logic [SETS-1:0]       valid_q;
   logic [TB-1:0]         tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS];
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [NB-1:0]         mem_be_q;
   logic [31:0]           hit_count_q, miss_count_q;

   // In IDLE the lookup uses the live CPU address; otherwise the latched transaction address.
   logic [ADDR_WIDTH-1:0] lk_addr;
   logic [IB-1:0]         idx;
   logic [TB-1:0]         tag;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] cpu_addr_al;
   logic                  unused_addr_bits;

   assign lk_addr          = (state_q == S_IDLE) ? cpu_addr : mem_addr_q;
   assign idx              = lk_addr[IB+1:2];
   assign tag              = lk_addr[ADDR_WIDTH-1:IB+2];
   assign hit              = valid_q[idx] && (tag_q[idx] == tag);
   assign cpu_addr_al      = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
   assign unused_addr_bits = ^lk_addr[1:0];

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_we)             state_d = S_WRITE;
            else if (cpu_re && !hit) state_d = S_FETCH;
         end
         S_FETCH, S_WRITE: begin
            if (mem_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall     = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_we)      stall = 1'b1;
            else if (cpu_re) begin
               if (hit) cpu_rdata = data_q[idx];
               else     stall     = 1'b1;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            stall   = !mem_ready;
            if (mem_ready) cpu_rdata = mem_rdata;
         end
         S_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            stall   = !mem_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cpu_we) begin
                  mem_addr_q  <= cpu_addr_al;
                  mem_wdata_q <= cpu_wdata;
                  mem_be_q    <= cpu_be;
               end else if (cpu_re && !hit) begin
                  mem_addr_q   <= cpu_addr_al;
                  miss_count_q <= miss_count_q + 32'd1;
               end else if (cpu_re) begin
                  hit_count_q <= hit_count_q + 32'd1;
               end
            end
            S_FETCH: if (mem_ready) valid_q[idx] <= 1'b1;
            default: ;
         endcase
      end
   end

   // Line payload needs no reset: valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (state_q == S_FETCH && mem_ready && !rst) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= mem_rdata;
      end else if (state_q == S_WRITE && mem_ready && hit && !rst) begin
         for (int b = 0; b < NB; b++) begin
            if (mem_be_q[b]) data_q[idx][8*b +: 8] <= mem_wdata_q[8*b +: 8];
         end
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_be     = mem_be_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: vector table of accesses with a response memory and rdata scoreboard,
// plus hand-written reset-mid-fetch and zero-wait-memory sequences.
module tb_data_cache;
   logic        clk = 1'b0;
   logic        rst, cpu_re, cpu_we, mem_ready;
   logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;
   logic        stall, mem_req, mem_we;
   logic [3:0]  mem_be;

   int compares = 0;
   int errors   = 0;
   bit tie_ready = 1'b0;

   logic [31:0] mem_model [bit [31:0]];
   logic [31:0] sb_q [$];

   typedef struct {
      bit          re;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          wait_n;
      logic [31:0] exp_rdata;
      int          exp_stalls;
      int          exp_hits;
      int          exp_misses;
   } vec_t;
   vec_t vecs[13];

   data_cache dut (
      .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after the counters settle.
   task automatic access(input string nm, input bit re, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int wait_n,
                         input logic [31:0] exp_rdata, input int exp_stalls,
                         input int exp_hits, input int exp_misses);
      int          stall_n = 0;
      int          req_n   = 0;
      bit          done    = 1'b0;
      logic [31:0] wa;
      wa        = {addr[31:2], 2'b00};
      cpu_re    = re;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_be    = be;
      mem_ready = tie_ready;
      mem_rdata = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
      if (!we) sb_q.push_back(exp_rdata);
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         if (mem_req) begin
            if (req_n == 0) begin
               chk({nm, "_mem_addr"}, mem_addr, wa);
               chk({nm, "_mem_we"}, {31'b0, mem_we}, {31'b0, we});
               if (we) begin
                  chk({nm, "_mem_wdata"}, mem_wdata, wdata);
                  chk({nm, "_mem_be"}, {28'b0, mem_be}, {28'b0, be});
               end
            end
            req_n++;
         end
         if (!stall) begin
            done = 1'b1;
            if (!we) begin
               if (sb_q.size() == 0) chk({nm, "_sb_empty"}, 32'd1, 32'd0);
               else chk({nm, "_rdata"}, cpu_rdata, sb_q.pop_front());
            end else begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) begin
                     logic [31:0] w;
                     w = mem_model.exists(wa) ? mem_model[wa] : 32'h0;
                     w[8*b +: 8] = wdata[8*b +: 8];
                     mem_model[wa] = w;
                  end
            end
         end else begin
            stall_n++;
         end
         @(posedge clk);
         #1;
         if (!done && mem_req) mem_ready = tie_ready || (req_n >= wait_n);
      end
      if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
      chk({nm, "_stalls"}, stall_n, exp_stalls);
      chk({nm, "_req_cycles"}, req_n, exp_stalls);
      chk({nm, "_hits"}, hit_count, exp_hits);
      chk({nm, "_misses"}, miss_count, exp_misses);
      cpu_re    = 1'b0;
      cpu_we    = 1'b0;
      mem_ready = tie_ready;
   endtask

   initial begin
      rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      cpu_be = '0; mem_ready = 1'b0; mem_rdata = '0;
      mem_model[32'h10]  = 32'hDEADBEEF;
      mem_model[32'h110] = 32'h11112222;
      mem_model[32'h20]  = 32'h0BADF00D;
      mem_model[32'h30]  = 32'h33333333;
      mem_model[32'h40]  = 32'h44444444;
      mem_model[32'h50]  = 32'h50505050;
      mem_model[32'h60]  = 32'h60606060;

      //            re we addr      wdata         be    wait rdata         st h  m
      vecs[0]  = '{1, 0, 32'h10,  32'h0,        4'h0, 2, 32'hDEADBEEF, 3, 0, 1};
      vecs[1]  = '{1, 0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF, 0, 1, 1};
      vecs[2]  = '{1, 0, 32'h110, 32'h0,        4'h0, 1, 32'h11112222, 2, 1, 2};
      vecs[3]  = '{1, 0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF, 1, 1, 3};
      vecs[4]  = '{0, 1, 32'h10,  32'h000000AA, 4'h1, 1, 32'h0,        2, 1, 3};
      vecs[5]  = '{1, 0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 0, 2, 3};
      vecs[6]  = '{0, 1, 32'h20,  32'hCAFEF00D, 4'hF, 0, 32'h0,        1, 2, 3};
      vecs[7]  = '{1, 0, 32'h20,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1, 2, 4};
      vecs[8]  = '{1, 0, 32'h20,  32'h0,        4'h0, 0, 32'hCAFEF00D, 0, 3, 4};
      vecs[9]  = '{0, 1, 32'h10,  32'h55660000, 4'hC, 0, 32'h0,        1, 3, 4};
      vecs[10] = '{1, 0, 32'h10,  32'h0,        4'h0, 0, 32'h5566BEAA, 0, 4, 4};
      vecs[11] = '{1, 1, 32'h30,  32'h77777777, 4'hF, 0, 32'h0,        1, 4, 4};
      vecs[12] = '{1, 0, 32'h30,  32'h0,        4'h0, 0, 32'h77777777, 1, 4, 5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i])
         access($sformatf("v%0d", i), vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].wait_n, vecs[i].exp_rdata, vecs[i].exp_stalls,
                vecs[i].exp_hits, vecs[i].exp_misses);

      // Reset in the middle of a fetch abandons it and clears the cache.
      cpu_re = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b0;
      @(negedge clk);
      chk("fr_idle_stall", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fr_fetch_req", {31'b0, mem_req}, 32'd1);
      chk("fr_fetch_stall", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; cpu_re = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("fr_mem_req", {31'b0, mem_req}, 32'd0);
      chk("fr_stall", {31'b0, stall}, 32'd0);
      chk("fr_mem_addr", mem_addr, 32'd0);
      chk("fr_misses", miss_count, 32'd0);
      chk("fr_hits", hit_count, 32'd0);
      @(posedge clk); #1;
      access("fr_reload", 1, 0, 32'h10, 32'h0, 4'h0, 0, 32'h5566BEAA, 1, 0, 1);

      // Zero-wait memory: mem_ready stays high, including while idle.
      tie_ready = 1'b1;
      mem_ready = 1'b1;
      access("zw_ld50a", 1, 0, 32'h50, 32'h0, 4'h0, 0, 32'h50505050, 1, 0, 2);
      access("zw_ld50b", 1, 0, 32'h50, 32'h0, 4'h0, 0, 32'h50505050, 0, 1, 2);
      access("zw_ld60a", 1, 0, 32'h60, 32'h0, 4'h0, 0, 32'h60606060, 1, 1, 3);
      access("zw_ld60b", 1, 0, 32'h60, 32'h0, 4'h0, 0, 32'h60606060, 0, 2, 3);
      access("zw_st60",  0, 1, 32'h60, 32'h12345678, 4'hF, 0, 32'h0, 1, 2, 3);
      access("zw_ld60c", 1, 0, 32'h60, 32'h0, 4'h0, 0, 32'h12345678, 0, 3, 3);
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end
endmodule
